multicycle_control_unit: RTL and testbench

- Main control FSM for the 32-bit RV32I multi-cycle datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Decodes the registered Op/Funct3/Funct7 fields and the ALU Zero flag into every datapath control strobe.
- Sits beside the datapath in the CPU top level; the CPU makes no other control decisions.

---
 rtl/multicycle_control_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Main control FSM for the RV32I multi-cycle datapath. Sequences
//            fetch / decode / execute / memory / writeback and decodes the
//            registered Op/Funct3/Funct7 fields plus the ALU Zero flag into
//            every datapath control strobe.
// Ports    : clk, reset (async, active-low)
//            Op[6:0], Funct3[2:0], Funct7[6:0], Zero       - decode inputs
//            IRWrite, IorD, MemWrite, RegWrite, MemtoReg,
//            ALUSrcA, ALUSrcB, ALUControl, PCEn, PCSrc     - datapath strobes
//            illegal_instr                                 - HALT indicator
//            state                                         - debug state
// Options  : ILLEGAL_TRAP_EN - undefined opcodes park the FSM in HALT until
//            reset; when undefined they retire as a 2-cycle NOP.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int STATE_WIDTH    = 5,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                Op,
  input  logic [2:0]                Funct3,
  input  logic [6:0]                Funct7,
  input  logic                      Zero,
  output logic                      IRWrite,
  output logic                      IorD,
  output logic                      MemWrite,
  output logic                      RegWrite,
  output logic [1:0]                MemtoReg,
  output logic [1:0]                ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic                      PCEn,
  output logic [1:0]                PCSrc,
  output logic                      illegal_instr,
  output logic [STATE_WIDTH-1:0]    state
);

  localparam logic [STATE_WIDTH-1:0] S_FETCH     = STATE_WIDTH'(0);
  localparam logic [STATE_WIDTH-1:0] S_DECODE    = STATE_WIDTH'(1);
  localparam logic [STATE_WIDTH-1:0] S_MEM_ADR   = STATE_WIDTH'(2);
  localparam logic [STATE_WIDTH-1:0] S_MEM_READ  = STATE_WIDTH'(3);
  localparam logic [STATE_WIDTH-1:0] S_MEM_WB    = STATE_WIDTH'(4);
  localparam logic [STATE_WIDTH-1:0] S_MEM_WRITE = STATE_WIDTH'(5);
  localparam logic [STATE_WIDTH-1:0] S_EXEC_R    = STATE_WIDTH'(6);
  localparam logic [STATE_WIDTH-1:0] S_EXEC_I    = STATE_WIDTH'(7);
  localparam logic [STATE_WIDTH-1:0] S_ALU_WB    = STATE_WIDTH'(8);
  localparam logic [STATE_WIDTH-1:0] S_BRANCH    = STATE_WIDTH'(9);
  localparam logic [STATE_WIDTH-1:0] S_JAL       = STATE_WIDTH'(10);
  localparam logic [STATE_WIDTH-1:0] S_JALR      = STATE_WIDTH'(11);
  localparam logic [STATE_WIDTH-1:0] S_JALR_PC   = STATE_WIDTH'(12);
  localparam logic [STATE_WIDTH-1:0] S_JAL_WB    = STATE_WIDTH'(13);
  localparam logic [STATE_WIDTH-1:0] S_LUI       = STATE_WIDTH'(14);
  localparam logic [STATE_WIDTH-1:0] S_AUIPC     = STATE_WIDTH'(15);
`ifdef ILLEGAL_TRAP_EN
  localparam logic [STATE_WIDTH-1:0] S_HALT      = STATE_WIDTH'(16);
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD  = ALU_CTRL_WIDTH'(4'b0000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB  = ALU_CTRL_WIDTH'(4'b0001);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND  = ALU_CTRL_WIDTH'(4'b0010);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR   = ALU_CTRL_WIDTH'(4'b0011);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR  = ALU_CTRL_WIDTH'(4'b0100);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL  = ALU_CTRL_WIDTH'(4'b0101);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL  = ALU_CTRL_WIDTH'(4'b0110);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA  = ALU_CTRL_WIDTH'(4'b0111);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT  = ALU_CTRL_WIDTH'(4'b1000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU = ALU_CTRL_WIDTH'(4'b1001);

  logic [STATE_WIDTH-1:0] r_state;
  logic [STATE_WIDTH-1:0] w_state_nxt;
  logic                   w_alt;      // Funct7[5] qualified for the current format
  logic [ALU_CTRL_WIDTH-1:0] w_alu_op;
  logic                   w_taken;
  logic                   w_unused;

  // Only Funct7[5] selects SUB/SRA; the remaining bits are don't-care here.
  assign w_unused = ^{Funct7[6], Funct7[4:0]};

  // I-type ADDI has no SUB form, so Funct7 is ignored when Funct3=000.
  assign w_alt = Funct7[5] & ((r_state == S_EXEC_R) | (Funct3 != 3'b000));

  always_comb begin
    case (Funct3)
      3'b000:  w_alu_op = w_alt ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op = ALU_SLL;
      3'b010:  w_alu_op = ALU_SLT;
      3'b011:  w_alu_op = ALU_SLTU;
      3'b100:  w_alu_op = ALU_XOR;
      3'b101:  w_alu_op = w_alt ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_op = ALU_OR;
      default: w_alu_op = ALU_AND;
    endcase
  end

  // Branch compare: SUB for eq/ne, SLT/SLTU for the ordered compares; the
  // ordered "less-than" forms are taken when the set-less-than result is
  // non-zero, the "greater-or-equal" forms when it is zero.
  always_comb begin
    case (Funct3)
      3'b000, 3'b101, 3'b111: w_taken = Zero;
      3'b001, 3'b100, 3'b110: w_taken = ~Zero;
      default:                w_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = S_FETCH;
    case (r_state)
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: w_state_nxt = S_MEM_ADR;
          OP_RTYPE:          w_state_nxt = S_EXEC_R;
          OP_ITYPE:          w_state_nxt = S_EXEC_I;
          OP_BRANCH:         w_state_nxt = S_BRANCH;
          OP_JAL:            w_state_nxt = S_JAL;
          OP_JALR:           w_state_nxt = S_JALR;
          OP_LUI:            w_state_nxt = S_LUI;
          OP_AUIPC:          w_state_nxt = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:           w_state_nxt = S_HALT;
`else
          default:           w_state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR:   w_state_nxt = (Op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_state_nxt = S_MEM_WB;
      S_EXEC_R,
      S_EXEC_I,
      S_LUI,
      S_AUIPC:     w_state_nxt = S_ALU_WB;
      S_JAL:       w_state_nxt = S_JAL_WB;
      S_JALR:      w_state_nxt = S_JALR_PC;
      S_JALR_PC:   w_state_nxt = S_JAL_WB;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:      w_state_nxt = S_HALT;
`endif
      default:     w_state_nxt = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    IRWrite       = 1'b0;
    IorD          = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    MemtoReg      = 2'd0;
    ALUSrcA       = 2'd0;
    ALUSrcB       = 2'd0;
    ALUControl    = ALU_ADD;
    PCEn          = 1'b0;
    PCSrc         = 2'd0;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        PCEn    = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd2;
      end
      S_MEM_ADR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
      end
      S_MEM_READ:  IorD = 1'b1;
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA    = 2'd1;
        ALUControl = w_alu_op;
      end
      S_EXEC_I: begin
        ALUSrcA    = 2'd1;
        ALUSrcB    = 2'd2;
        ALUControl = w_alu_op;
      end
      S_LUI: begin
        ALUSrcA = 2'd3;
        ALUSrcB = 2'd2;
      end
      S_AUIPC: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd2;
      end
      S_ALU_WB, S_JAL_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'd1;
        PCSrc      = 2'd1;
        PCEn       = w_taken;
        ALUControl = (Funct3[2:1] == 2'b10) ? ALU_SLT  :
                     (Funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
      end
      // The link value PC (already PC+4) passes through the ALU while the
      // target held in ALUOut is loaded into the PC.
      S_JAL, S_JALR_PC: begin
        ALUSrcB = 2'd3;
        PCSrc   = 2'd1;
        PCEn    = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: illegal_instr = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Purpose  : Self-checking bench for multicycle_control_unit. Each instruction
//            is expanded into its expected per-cycle list of control vectors
//            and compared cycle by cycle. Honours ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       Zero;
  logic       IRWrite, IorD, MemWrite, RegWrite, PCEn, illegal_instr;
  logic [1:0] MemtoReg, ALUSrcA, ALUSrcB, PCSrc;
  logic [3:0] ALUControl;
  logic [4:0] state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.STATE_WIDTH(5), .ALU_CTRL_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct3(Funct3), .Funct7(Funct7),
    .Zero(Zero), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCEn(PCEn), .PCSrc(PCSrc),
    .illegal_instr(illegal_instr), .state(state)
  );

  // Vector layout: {IRWrite, IorD, MemWrite, RegWrite, MemtoReg, SrcA, SrcB,
  //                 ALUControl, PCEn, PCSrc, illegal_instr}
  wire [17:0] w_obs = {IRWrite, IorD, MemWrite, RegWrite, MemtoReg, ALUSrcA,
                       ALUSrcB, ALUControl, PCEn, PCSrc, illegal_instr};
  localparam logic [17:0] c_alu_mask = 18'h3FF0F;

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
    end
  endtask

  typedef enum int {K_R, K_I, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_ILL} kind_t;

  function automatic kind_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int cycles(input kind_t k);
    case (k)
      K_LOAD, K_JALR: return 5;
      K_BR:           return 3;
      K_ILL:          return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [17:0] mk(input bit irw, input bit iord, input bit mw,
      input bit rw, input int mtr, input int sa, input int sb, input int alu,
      input bit pcen, input int pcsrc, input bit ill);
    return {irw, iord, mw, rw, 2'(mtr), 2'(sa), 2'(sb), 4'(alu), pcen, 2'(pcsrc), ill};
  endfunction

  // Arithmetic-op naming by funct3; alt selects SUB/SRA.
  function automatic int alu_name(input logic [2:0] f3, input bit alt);
    int tbl [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    if (f3 == 3'd0 && alt) return 1;
    if (f3 == 3'd5 && alt) return 7;
    return tbl[f3];
  endfunction

  function automatic bit br_taken(input logic [2:0] f3, input bit z);
    case (f3)
      3'd0: return z;      // beq: difference zero
      3'd1: return !z;     // bne
      3'd4: return !z;     // blt: slt result 1
      3'd5: return z;      // bge
      3'd6: return !z;     // bltu
      3'd7: return z;      // bgeu
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [17:0] expect_vec(input kind_t k, input logic [2:0] f3,
      input logic [6:0] f7, input bit z, input int step);
    logic [17:0] wb;
    wb = mk(0,0,0,1,0,0,0,0,0,0,0);
    if (step == 0) return mk(1,0,0,0,0,0,1,0,1,0,0);
    if (step == 1) return mk(0,0,0,0,0,2,2,0,0,0,0);
    case (k)
      K_R:     return (step == 2) ? mk(0,0,0,0,0,1,0,alu_name(f3, f7[5]),0,0,0) : wb;
      K_I:     return (step == 2) ? mk(0,0,0,0,0,1,2,alu_name(f3, (f3 != 0) && f7[5]),0,0,0) : wb;
      K_LUI:   return (step == 2) ? mk(0,0,0,0,0,3,2,0,0,0,0) : wb;
      K_AUIPC: return (step == 2) ? mk(0,0,0,0,0,2,2,0,0,0,0) : wb;
      K_LOAD:  return (step == 2) ? mk(0,0,0,0,0,1,2,0,0,0,0) :
                      (step == 3) ? mk(0,1,0,0,0,0,0,0,0,0,0) :
                                    mk(0,0,0,1,1,0,0,0,0,0,0);
      K_STORE: return (step == 2) ? mk(0,0,0,0,0,1,2,0,0,0,0) :
                                    mk(0,1,1,0,0,0,0,0,0,0,0);
      K_BR:    return mk(0,0,0,0,0,1,0, (f3[2:1] == 2'b10) ? 8 : (f3[2:1] == 2'b11) ? 9 : 1,
                         br_taken(f3, z), 1, 0);
      K_JAL:   return (step == 2) ? mk(0,0,0,0,0,0,3,0,1,1,0) : wb;
      K_JALR:  return (step == 2) ? mk(0,0,0,0,0,1,2,0,0,0,0) :
                      (step == 3) ? mk(0,0,0,0,0,0,3,0,1,1,0) : wb;
      default: return 18'h0;
    endcase
  endfunction

  // Entry: just after a negedge with the DUT in FETCH. Exit: same condition.
  // zmode: -1 random Zero, else the fixed value. abort_step >= 0 asserts
  // reset in the middle of that step.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input int zmode, input int abort_step);
    kind_t k = classify(op);
    logic [17:0] e;
    Op = op; Funct3 = f3; Funct7 = f7;
    for (int s = 0; s < cycles(k); s++) begin
      Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      e = expect_vec(k, f3, f7, Zero, s);
      if (k == K_BR && f3[2:1] == 2'b01)
        chk($sformatf("op%07b f3=%0d step%0d", op, f3, s), w_obs & c_alu_mask, e & c_alu_mask);
      else
        chk($sformatf("op%07b f3=%0d step%0d", op, f3, s), w_obs, e);
      if (s == abort_step) begin
        reset = 1'b0;
        #1;
        chk("async reset MemWrite", {17'd0, MemWrite}, 18'd0);
        chk("async reset vector", w_obs, mk(1,0,0,0,0,0,1,0,1,0,0));
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      @(negedge clk);
    end
`ifdef ILLEGAL_TRAP_EN
    if (k == K_ILL) begin
      for (int c = 0; c < 20; c++) begin
        Zero = 1'($urandom_range(0, 1));
        Op = 7'($urandom);
        #1;
        chk($sformatf("halt cycle%0d", c), w_obs, mk(0,0,0,0,0,0,0,0,0,0,1));
        @(negedge clk);
      end
      reset = 1'b0;
      #1;
      chk("halt released by reset", w_obs, mk(1,0,0,0,0,0,1,0,1,0,0));
      @(negedge clk);
      reset = 1'b1;
    end
`endif
  endtask

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [6:0] op;
    reset = 1'b0; Op = 7'b0110011; Funct3 = 3'd0; Funct7 = 7'd0; Zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset vector", w_obs, mk(1,0,0,0,0,0,1,0,1,0,0));
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    run_instr(7'b0110011, 3'd0, 7'b0100000, -1, -1);  // sub
    run_instr(7'b0010011, 3'd0, 7'b0100000, -1, -1);  // addi ignores funct7
    run_instr(7'b0010011, 3'd5, 7'b0100000, -1, -1);  // srai
    run_instr(7'b0000011, 3'd2, 7'd0, -1, -1);        // lw
    run_instr(7'b0100011, 3'd2, 7'd0, -1, -1);        // sw
    run_instr(7'b1100011, 3'd1, 7'd0, 0, -1);         // bne taken
    run_instr(7'b1100011, 3'd1, 7'd0, 1, -1);         // bne not taken
    run_instr(7'b1100011, 3'd5, 7'd0, 1, -1);         // bge taken
    run_instr(7'b1100011, 3'd2, 7'd0, 1, -1);         // undefined branch never taken
    run_instr(7'b1100111, 3'd0, 7'd0, -1, -1);        // jalr
    run_instr(7'b1101111, 3'd0, 7'd0, -1, -1);        // jal
    run_instr(7'b0100011, 3'd2, 7'd0, -1, 3);         // reset during MEM_WRITE
    run_instr(7'b0110111, 3'd0, 7'd0, -1, -1);        // lui after reset recovery
    run_instr(7'b1111111, 3'd0, 7'd0, -1, -1);        // illegal opcode

    // Randomised instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else op = legal_ops[$urandom_range(0, 8)];
      run_instr(op, 3'($urandom), 7'($urandom), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
